id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
RV32I decode stage. Consumes the fetch stage's pc/instr/valid and drives the fetch stage's stall, branch/jump target and take signals back, i.e. the IF-side control handshake.
- Holds the IF/ID pipeline register.
- Decodes register indices, immediate and control bits for EX.
- Detects load-use hazards.
- Resolves JAL early.
- Squashes its contents on an EX-stage redirect.

Parameters:
XLEN, 32, datapath/pc width (only 32 supported)
NOP_INSTR, 32'h00000013, instruction loaded on reset/flush/bubble (addi x0,x0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
pc_i  in  32  pc from IF
instr_i  in  32  instruction from IF
valid_i  in  1  IF output valid
ex_take_bj_i  in  1  EX redirect (branch taken / JALR); flushes ID
ex_mem_read_i  in  1  instruction currently in EX is a load
ex_rd_i  in  5  destination register of EX instruction
stall_o  out  1  to IF stall_i
take_bj_o  out  1  to IF take_bj_sig_i
pc_bj_o  out  32  to IF pc_bj_i (JAL target)
pc_o  out  32  registered pc to EX
instr_o  out  32  registered instruction to EX
valid_o  out  1  instruction to EX is real (0 = bubble)
rs1_o  out  5  instr[19:15]
rs2_o  out  5  instr[24:20]
rd_o  out  5  instr[11:7]
imm_o  out  32  sign-extended immediate
reg_write_o  out  1  writes rd (forced 0 when rd=0 or !valid_o)
mem_read_o  out  1  load
mem_write_o  out  1  store
illegal_o  out  1  valid instruction with unsupported opcode

Behaviour:
- State: pc_q, instr_q, valid_q. Decode is combinational from these registers.
- Latency: IF beat at edge N is visible on the outputs after edge N.
- Reset (async, immediate): pc_q=0, instr_q=NOP_INSTR, valid_q=0. Every output is then 0 except instr_o=0x00000013 and imm_o=0.
- Load-use hazard, all of the following true:
  - valid_q=1
  - ex_mem_read_i=1
  - ex_rd_i!=0
  - ex_rd_i==rs1 with rs1 used, or ex_rd_i==rs2 with rs2 used
- rs1 used: R, I-ALU, load, store, branch, JALR. rs2 used: R, store, branch.
- On hazard: stall_o=1; registers hold; valid_o, reg_write_o, mem_read_o, mem_write_o forced 0 (bubble to EX).
- Flush: ex_take_bj_i=1 loads NOP/valid 0 on the next edge. Flush overrides stall. stall_o is masked to 0 while ex_take_bj_i=1.
- JAL resolve, when valid_q=1, opcode=1101111, no hazard and no flush:
  - take_bj_o=1 and pc_bj_o=pc_q+imm_J (mod 2^32, no overflow detect).
  - Next edge loads a bubble, discarding the wrong-path IF beat, so take_bj_o is exactly 1 cycle.
  - The JAL itself proceeds to EX with valid_o=1 for the link write.
- Otherwise take_bj_o=0 and pc_bj_o=0.
- Normal capture: no stall and no flush -> register loads pc_i/instr_i/valid_i. valid_i=0 captures a bubble.
- Immediates, sign-extended from bit 31:
  - I: loads, OP-IMM, JALR
  - S: stores
  - B: branches
  - U: LUI, AUIPC
  - J: JAL
  - imm_o=0 for R-type, SYSTEM and illegal opcodes.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011.
- illegal_o=valid_q & opcode not in the legal set. An illegal instruction still flows with valid_o=1 and no reg/mem write.

Optional Feature:
ID_JAL_RESOLVE_EN
- Defined: JAL is redirected from ID as described above.
- Undefined: take_bj_o and pc_bj_o are tied 0, no post-JAL bubble is inserted, and JAL is resolved by EX through ex_take_bj_i.

Test Plan:
- Reset: assert rst_i mid-run -> immediately valid_o=0, instr_o=0x00000013, stall_o=0, take_bj_o=0, pc_o=0.
- Decode: pc_i=0x0, instr_i=0x00500093 (addi x1,x0,5), valid_i=1 -> after edge: rd_o=1, rs1_o=0, imm_o=5, reg_write_o=1, valid_o=1, illegal_o=0.
- Load-use stall:
  - ID holds 0x002081B3 (add x3,x1,x2) with ex_mem_read_i=1, ex_rd_i=1 -> stall_o=1, valid_o=0, register unchanged across 2 edges.
  - Same with ex_rd_i=0 -> stall_o=0.
- JAL (feature on): instr 0x010000EF at pc 0x8 -> take_bj_o=1, pc_bj_o=0x18 for exactly 1 cycle, rd_o=1, valid_o=1; next cycle valid_o=0 regardless of IF beat. Feature off -> take_bj_o stays 0.
- Flush beats stall: load-use condition with ex_take_bj_i=1 -> stall_o=0; after edge valid_o=0, instr_o=0x00000013.
- Illegal: instr 0xFFFFFFFF valid -> illegal_o=1, reg_write_o=0, mem_read_o=0, mem_write_o=0, imm_o=0.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage.
// Holds the IF/ID pipeline register and decodes it for EX. It also detects
// load-use hazards and squashes its contents on an EX redirect.
// Optional feature macro: ID_JAL_RESOLVE_EN. When defined, JAL is redirected
// from this stage. When undefined, take_bj_o and pc_bj_o are tied to zero and
// EX resolves JAL through ex_take_bj_i.
module id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            valid_i,
  input  logic            ex_take_bj_i,
  input  logic            ex_mem_read_i,
  input  logic [4:0]      ex_rd_i,
  output logic            stall_o,
  output logic            take_bj_o,
  output logic [XLEN-1:0] pc_bj_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [31:0]     imm_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            illegal_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i_val;
  logic [31:0] imm_s_val;
  logic [31:0] imm_b_val;
  logic [31:0] imm_u_val;
  logic [31:0] imm_j_val;

  logic        legal;
  logic        rs1_used;
  logic        rs2_used;
  logic        writes_rd;
  logic        is_load;
  logic        is_store;
  logic        is_jal;
  logic [31:0] imm;

  logic        hazard;
  logic        jal_take;

  assign opcode = instr_q[6:0];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign rd     = instr_q[11:7];

  assign imm_i_val = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s_val = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b_val = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u_val = {instr_q[31:12], 12'h000};
  assign imm_j_val = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // Opcode classification: legality, operand usage, side effects and immediate format
  always_comb begin
    legal     = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_jal    = 1'b0;
    imm       = 32'h0;
    case (opcode)
      OP_R: begin
        legal     = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_IMM: begin
        legal     = 1'b1;
        rs1_used  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_i_val;
      end
      OP_LOAD: begin
        legal     = 1'b1;
        rs1_used  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
        imm       = imm_i_val;
      end
      OP_STORE: begin
        legal    = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        is_store = 1'b1;
        imm      = imm_s_val;
      end
      OP_BRANCH: begin
        legal    = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = imm_b_val;
      end
      OP_JAL: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        is_jal    = 1'b1;
        imm       = imm_j_val;
      end
      OP_JALR: begin
        legal     = 1'b1;
        rs1_used  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_i_val;
      end
      OP_LUI, OP_AUIPC: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_u_val;
      end
      OP_FENCE, OP_SYSTEM: begin
        legal = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // A load in EX whose destination feeds a used source here must stall ID
  always_comb begin
    hazard = valid_q && ex_mem_read_i && (ex_rd_i != 5'd0) &&
             ((rs1_used && (ex_rd_i == rs1)) || (rs2_used && (ex_rd_i == rs2)));
  end

`ifdef ID_JAL_RESOLVE_EN
  // Early JAL redirect; suppressed while stalled or being flushed by EX
  always_comb begin
    jal_take = valid_q && is_jal && !hazard && !ex_take_bj_i;
  end

  assign take_bj_o = jal_take;
  assign pc_bj_o   = jal_take ? (pc_q + imm_j_val) : '0;
`else
  assign jal_take  = 1'b0;
  assign take_bj_o = 1'b0;
  assign pc_bj_o   = '0;
`endif

  // IF/ID register: flush beats stall, stall holds, a taken JAL drops the wrong-path beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (ex_take_bj_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (hazard) begin
      pc_q    <= pc_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
    end else if (jal_take) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= valid_i;
    end
  end

  assign stall_o     = hazard && !ex_take_bj_i;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign valid_o     = valid_q && !hazard;
  assign rs1_o       = rs1;
  assign rs2_o       = rs2;
  assign rd_o        = rd;
  assign imm_o       = imm;
  assign reg_write_o = valid_o && writes_rd && (rd != 5'd0);
  assign mem_read_o  = valid_o && is_load;
  assign mem_write_o = valid_o && is_store;
  assign illegal_o   = valid_q && !legal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a
// behavioural model of the decode stage kept in this file.
module tb_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        ex_take_bj_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rd_i;
  logic        stall_o;
  logic        take_bj_o;
  logic [31:0] pc_bj_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [31:0] imm_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

`ifdef ID_JAL_RESOLVE_EN
  localparam bit JalEarly = 1'b1;
`else
  localparam bit JalEarly = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Reference model state: what the IF/ID register should hold
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;

  id_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i), .valid_i(valid_i),
    .ex_take_bj_i(ex_take_bj_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .stall_o(stall_o), .take_bj_o(take_bj_o), .pc_bj_o(pc_bj_o), .pc_o(pc_o),
    .instr_o(instr_o), .valid_o(valid_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .imm_o(imm_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit isLegal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
  endfunction

  function automatic bit usesRs1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit usesRs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit writesRd(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction

  // Immediate built arithmetically from the instruction word's fields
  function automatic logic [31:0] modelImm(input logic [31:0] ins);
    logic [31:0] top1;
    logic [31:0] top12;
    top1  = 32'($signed(ins) >>> 31);
    top12 = 32'($signed(ins) >>> 20);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return top12;
      7'h23: return ((top12 >> 5) << 5) | 32'(ins[11:7]);
      7'h63: return (top1 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return (top1 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit modelHazard();
    logic [4:0] r1;
    logic [4:0] r2;
    r1 = m_instr[19:15];
    r2 = m_instr[24:20];
    return m_valid && ex_mem_read_i && (ex_rd_i != 0) &&
           ((usesRs1(m_instr[6:0]) && ex_rd_i == r1) || (usesRs2(m_instr[6:0]) && ex_rd_i == r2));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current inputs
  task automatic compareAll();
    bit          hz;
    bit          jal;
    bit          vo;
    logic [6:0]  op;
    op  = m_instr[6:0];
    hz  = modelHazard();
    jal = JalEarly && m_valid && op == 7'h6F && !hz && !ex_take_bj_i;
    vo  = m_valid && !hz;
    checkOutput("stall", 32'(stall_o), 32'(hz && !ex_take_bj_i));
    checkOutput("take_bj", 32'(take_bj_o), 32'(jal));
    checkOutput("pc_bj", pc_bj_o, jal ? m_pc + modelImm(m_instr) : 32'h0);
    checkOutput("valid", 32'(valid_o), 32'(vo));
    checkOutput("reg_write", 32'(reg_write_o), 32'(vo && writesRd(op) && m_instr[11:7] != 0));
    checkOutput("mem_read", 32'(mem_read_o), 32'(vo && op == 7'h03));
    checkOutput("mem_write", 32'(mem_write_o), 32'(vo && op == 7'h23));
    checkOutput("illegal", 32'(illegal_o), 32'(m_valid && !isLegal(op)));
    if (m_valid) begin
      checkOutput("pc", pc_o, m_pc);
      checkOutput("instr", instr_o, m_instr);
      checkOutput("rs1", 32'(rs1_o), 32'(m_instr[19:15]));
      checkOutput("rs2", 32'(rs2_o), 32'(m_instr[24:20]));
      checkOutput("rd", 32'(rd_o), 32'(m_instr[11:7]));
      if (op != 7'h0F) checkOutput("imm", imm_o, modelImm(m_instr));
    end
  endtask

  // Drive one cycle: inputs after the falling edge, compare, clock, advance the model
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins, input logic vld,
                               input logic take, input logic mr, input logic [4:0] exrd);
    bit hz;
    bit jal;
    pc_i = pc; instr_i = ins; valid_i = vld;
    ex_take_bj_i = take; ex_mem_read_i = mr; ex_rd_i = exrd;
    #2;
    compareAll();
    hz  = modelHazard();
    jal = JalEarly && m_valid && m_instr[6:0] == 7'h6F && !hz && !take;
    @(posedge clk_i);
    if (take || jal) begin
      m_pc = 0; m_instr = NOP; m_valid = 0;
    end else if (!hz) begin
      m_pc = pc; m_instr = ins; m_valid = vld;
    end
    @(negedge clk_i);
  endtask

  task automatic checkReset();
    checkOutput("rst_valid", 32'(valid_o), 32'h0);
    checkOutput("rst_instr", instr_o, NOP);
    checkOutput("rst_stall", 32'(stall_o), 32'h0);
    checkOutput("rst_take_bj", 32'(take_bj_o), 32'h0);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_imm", imm_o, 32'h0);
    checkOutput("rst_reg_write", 32'(reg_write_o), 32'h0);
  endtask

  task automatic asyncReset();
    #2;
    rst_i = 1'b1;
    m_pc = 0; m_instr = NOP; m_valid = 0;
    #1;
    checkReset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] r;
    logic [6:0]  ops [13];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h7F, 7'h5B};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 12)];
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rst_i = 1'b1;
    pc_i = 0; instr_i = NOP; valid_i = 0;
    ex_take_bj_i = 0; ex_mem_read_i = 0; ex_rd_i = 0;
    m_pc = 0; m_instr = NOP; m_valid = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkReset();
    rst_i = 1'b0;

    // addi x1,x0,5
    applyStimulus(32'h0, 32'h0050_0093, 1, 0, 0, 0);
    #1;
    checkOutput("dec_rd", 32'(rd_o), 32'd1);
    checkOutput("dec_rs1", 32'(rs1_o), 32'd0);
    checkOutput("dec_imm", imm_o, 32'd5);
    checkOutput("dec_reg_write", 32'(reg_write_o), 32'd1);
    checkOutput("dec_valid", 32'(valid_o), 32'd1);
    checkOutput("dec_illegal", 32'(illegal_o), 32'd0);

    // add x3,x1,x2 behind a load to x1
    applyStimulus(32'h4, 32'h0020_81B3, 1, 0, 0, 0);
    ex_mem_read_i = 1; ex_rd_i = 5'd1;
    #1;
    checkOutput("lu_stall", 32'(stall_o), 32'd1);
    checkOutput("lu_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(32'h8, 32'h0050_0093, 1, 0, 1, 5'd1);
      #1;
      checkOutput("lu_hold_instr", instr_o, 32'h0020_81B3);
      checkOutput("lu_hold_pc", pc_o, 32'h4);
    end
    ex_rd_i = 5'd0;
    #1;
    checkOutput("lu_x0_stall", 32'(stall_o), 32'd0);
    checkOutput("lu_x0_valid", 32'(valid_o), 32'd1);

    // flush wins over the pending load-use stall
    ex_rd_i = 5'd1; ex_take_bj_i = 1;
    #1;
    checkOutput("fl_stall", 32'(stall_o), 32'd0);
    applyStimulus(32'h8, 32'h0050_0093, 1, 1, 1, 5'd1);
    ex_take_bj_i = 0; ex_mem_read_i = 0;
    #1;
    checkOutput("fl_valid", 32'(valid_o), 32'd0);
    checkOutput("fl_instr", instr_o, NOP);

    // jal x1,+16 at pc 0x8
    applyStimulus(32'h8, 32'h0100_00EF, 1, 0, 0, 0);
    #1;
    checkOutput("jal_rd", 32'(rd_o), 32'd1);
    checkOutput("jal_valid", 32'(valid_o), 32'd1);
    checkOutput("jal_take", 32'(take_bj_o), 32'(JalEarly));
    checkOutput("jal_target", pc_bj_o, JalEarly ? 32'h18 : 32'h0);
    applyStimulus(32'hC, 32'h0050_0093, 1, 0, 0, 0);
    #1;
    checkOutput("jal_next_valid", 32'(valid_o), 32'(!JalEarly));
    checkOutput("jal_next_take", 32'(take_bj_o), 32'd0);

    // all-ones word is not a legal opcode
    applyStimulus(32'h10, 32'hFFFF_FFFF, 1, 0, 0, 0);
    #1;
    checkOutput("ill_flag", 32'(illegal_o), 32'd1);
    checkOutput("ill_reg_write", 32'(reg_write_o), 32'd0);
    checkOutput("ill_mem_read", 32'(mem_read_o), 32'd0);
    checkOutput("ill_mem_write", 32'(mem_write_o), 32'd0);
    checkOutput("ill_imm", imm_o, 32'd0);

    // randomized traffic with occasional mid-run resets
    for (int n = 0; n < 400; n++) begin
      if (n % 97 == 50) asyncReset();
      applyStimulus({$urandom} & 32'hFFFF_FFFC, randomInstr(), ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
                    5'($urandom_range(0, 3)));
    end

    asyncReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
